// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath/memories.
// master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ALU_WIDTH  = 3,
    parameter int unsigned IMM_WIDTH  = 3
);
    logic                  imem_req;
    logic                  imem_ack;
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] ir;
    logic                  dmem_req;
    logic                  dmem_ack;
    logic                  alu_zero;
    logic [ALU_WIDTH-1:0]  alu_ctrl;
    logic                  alu_src;
    logic [IMM_WIDTH-1:0]  imm_src;
    logic                  reg_we;
    logic                  result_src;
    logic                  pc_we;
    logic                  pc_src;
    logic                  illegal;
    logic [DATA_WIDTH-1:0] instret;
    logic [2:0]            state;

    modport master (
        input  imem_ack, instr, dmem_ack, alu_zero,
        output imem_req, ir, dmem_req, alu_ctrl, alu_src, imm_src,
               reg_we, result_src, pc_we, pc_src, illegal, instret, state
    );

    modport slave (
        output imem_ack, instr, dmem_ack, alu_zero,
        input  imem_req, ir, dmem_req, alu_ctrl, alu_src, imm_src,
               reg_we, result_src, pc_we, pc_src, illegal, instret, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle controller for an addi/bne/lw subset: fetch, decode, execute,
// memory and writeback sequencing with a sticky illegal-instruction trap.
module multicycle_ctrl #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned OPCODE_WIDTH = 7,
    parameter int unsigned ALU_WIDTH    = 3,
    parameter int unsigned IMM_WIDTH    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_e;

    localparam logic [OPCODE_WIDTH-1:0] OP_IMM    = OPCODE_WIDTH'(7'b0010011);
    localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = OPCODE_WIDTH'(7'b1100011);
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD   = OPCODE_WIDTH'(7'b0000011);
    localparam logic [2:0]              F3_ADDI   = 3'b000;
    localparam logic [2:0]              F3_BNE    = 3'b001;
    localparam logic [2:0]              F3_LW     = 3'b010;
    localparam logic [ALU_WIDTH-1:0]    SUM_OP    = ALU_WIDTH'(3'b000);
    localparam logic [ALU_WIDTH-1:0]    SUB_OP    = ALU_WIDTH'(3'b001);
    localparam logic [IMM_WIDTH-1:0]    IMM_I     = IMM_WIDTH'(3'd0);
    localparam logic [IMM_WIDTH-1:0]    IMM_B     = IMM_WIDTH'(3'd3);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [DATA_WIDTH-1:0] instret_q, instret_d;
    logic                  illegal_q, illegal_d;

    logic [OPCODE_WIDTH-1:0] opcode;
    logic [2:0]              funct3;
    logic [4:0]              rd;
    logic                    is_addi, is_bne, is_lw;

    logic                  imem_req_c, dmem_req_c;
    logic [ALU_WIDTH-1:0]  alu_ctrl_c;
    logic                  alu_src_c;
    logic [IMM_WIDTH-1:0]  imm_src_c;
    logic                  reg_we_c, result_src_c, pc_we_c, pc_src_c;

    // Decode always looks at the latched IR, which is stable after FETCH.
    assign opcode  = ir_q[OPCODE_WIDTH-1:0];
    assign funct3  = ir_q[14:12];
    assign rd      = ir_q[11:7];
    assign is_addi = (opcode == OP_IMM)    && (funct3 == F3_ADDI);
    assign is_bne  = (opcode == OP_BRANCH) && (funct3 == F3_BNE);
    assign is_lw   = (opcode == OP_LOAD)   && (funct3 == F3_LW);

    // Next-state, register updates and control strobes.
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        instret_d    = instret_q;
        illegal_d    = illegal_q;
        imem_req_c   = 1'b0;
        dmem_req_c   = 1'b0;
        alu_ctrl_c   = SUM_OP;
        alu_src_c    = 1'b0;
        imm_src_c    = IMM_I;
        reg_we_c     = 1'b0;
        result_src_c = 1'b0;
        pc_we_c      = 1'b0;
        pc_src_c     = 1'b0;

        case (state_q)
            FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ack) begin
                    ir_d    = bus.instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (is_addi || is_bne || is_lw) begin
                    state_d = EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = TRAP;
                end
            end
            EXEC: begin
                if (is_bne) begin
                    alu_ctrl_c = SUB_OP;
                    imm_src_c  = IMM_B;
                    pc_we_c    = 1'b1;
                    pc_src_c   = ~bus.alu_zero;
                    instret_d  = instret_q + DATA_WIDTH'(1);
                    state_d    = FETCH;
                end else begin
                    alu_src_c = 1'b1;
                    state_d   = is_lw ? MEM : WB;
                end
            end
            MEM: begin
                dmem_req_c = 1'b1;
                alu_src_c  = 1'b1;
                if (bus.dmem_ack) begin
                    state_d = WB;
                end
            end
            WB: begin
                alu_src_c    = 1'b1;
                reg_we_c     = (rd != 5'd0);
                result_src_c = is_lw;
                pc_we_c      = 1'b1;
                instret_d    = instret_q + DATA_WIDTH'(1);
                state_d      = FETCH;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            ir_q      <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.imem_req   = imem_req_c;
    assign bus.dmem_req   = dmem_req_c;
    assign bus.alu_ctrl   = alu_ctrl_c;
    assign bus.alu_src    = alu_src_c;
    assign bus.imm_src    = imm_src_c;
    assign bus.reg_we     = reg_we_c;
    assign bus.result_src = result_src_c;
    assign bus.pc_we      = pc_we_c;
    assign bus.pc_src     = pc_src_c;
    assign bus.ir         = ir_q;
    assign bus.instret    = instret_q;
    assign bus.illegal    = illegal_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction sequencing, latency,
// x0 suppression, instret wrap, trap stickiness and reset behaviour.
module tb_multicycle_ctrl;
    localparam logic [31:0] ADDI_X5 = 32'h0070_0293;
    localparam logic [31:0] ADDI_X0 = 32'h0010_0013;
    localparam logic [31:0] BNE_8   = 32'h0020_9463;
    localparam logic [31:0] LW_X6   = 32'h0040_A303;
    localparam logic [31:0] R_TYPE  = 32'h0000_0033;

    logic        clk;
    logic        rst_n;
    int          n_cmp;
    int          n_err;
    int unsigned cyc;
    int unsigned t0;

    multicycle_ctrl_if #(.DATA_WIDTH(32), .ALU_WIDTH(3), .IMM_WIDTH(3)) bus ();

    multicycle_ctrl #(
        .DATA_WIDTH(32), .OPCODE_WIDTH(7), .ALU_WIDTH(3), .IMM_WIDTH(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present instr with an immediate ack in FETCH; returns in DECODE.
    task automatic fetch(input logic [31:0] word);
        bus.instr    = word;
        bus.imem_ack = 1'b1;
        t0           = cyc;
        step();
        bus.imem_ack = 1'b0;
        bus.instr    = 32'hDEAD_BEEF;
        #1;
    endtask

    task automatic run_addi(input logic [31:0] word);
        fetch(word);
        step();
        step();
        step();
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        bus.imem_ack = 1'b0;
        bus.instr    = 32'h0;
        bus.dmem_ack = 1'b0;
        bus.alu_zero = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;

        check("rst_state",    32'(bus.state), 32'd0);
        check("rst_imem_req", 32'(bus.imem_req), 32'd1);
        check("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        check("rst_reg_we",   32'(bus.reg_we), 32'd0);
        check("rst_pc_we",    32'(bus.pc_we), 32'd0);
        check("rst_alu_src",  32'(bus.alu_src), 32'd0);
        check("rst_imm_src",  32'(bus.imm_src), 32'd0);
        check("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
        check("rst_ir",       bus.ir, 32'd0);
        check("rst_instret",  bus.instret, 32'd0);
        check("rst_illegal",  32'(bus.illegal), 32'd0);

        // Fetch wait with a stray dmem_ack: stays in FETCH, request held.
        bus.dmem_ack = 1'b1;
        step();
        check("wait_state",    32'(bus.state), 32'd0);
        check("wait_imem_req", 32'(bus.imem_req), 32'd1);
        bus.dmem_ack = 1'b0;

        // addi x5,x0,7
        fetch(ADDI_X5);
        check("addi_dec_state", 32'(bus.state), 32'd1);
        check("addi_ir",        bus.ir, ADDI_X5);
        check("addi_dec_pc_we", 32'(bus.pc_we), 32'd0);
        step();
        check("addi_ex_state",  32'(bus.state), 32'd2);
        check("addi_ex_alusrc", 32'(bus.alu_src), 32'd1);
        check("addi_ex_reg_we", 32'(bus.reg_we), 32'd0);
        check("addi_ex_pc_we",  32'(bus.pc_we), 32'd0);
        step();
        check("addi_wb_state",  32'(bus.state), 32'd4);
        check("addi_wb_reg_we", 32'(bus.reg_we), 32'd1);
        check("addi_wb_pc_we",  32'(bus.pc_we), 32'd1);
        check("addi_wb_pc_src", 32'(bus.pc_src), 32'd0);
        check("addi_wb_res",    32'(bus.result_src), 32'd0);
        check("addi_wb_instr0", bus.instret, 32'd0);
        step();
        check("addi_end_state", 32'(bus.state), 32'd0);
        check("addi_instret",   bus.instret, 32'd1);
        check("addi_end_pc_we", 32'(bus.pc_we), 32'd0);
        check("addi_latency",   cyc - t0, 32'd4);

        // bne taken (alu_zero=0) then not taken (alu_zero=1)
        fetch(BNE_8);
        step();
        bus.alu_zero = 1'b0;
        #1;
        check("bne_ex_state",   32'(bus.state), 32'd2);
        check("bne_t_pc_we",    32'(bus.pc_we), 32'd1);
        check("bne_t_pc_src",   32'(bus.pc_src), 32'd1);
        check("bne_alu_ctrl",   32'(bus.alu_ctrl), 32'd1);
        check("bne_imm_src",    32'(bus.imm_src), 32'd3);
        check("bne_alu_src",    32'(bus.alu_src), 32'd0);
        check("bne_reg_we",     32'(bus.reg_we), 32'd0);
        step();
        check("bne_t_state",    32'(bus.state), 32'd0);
        check("bne_t_instret",  bus.instret, 32'd2);
        check("bne_t_latency",  cyc - t0, 32'd3);

        fetch(BNE_8);
        step();
        bus.alu_zero = 1'b1;
        #1;
        check("bne_n_pc_we",    32'(bus.pc_we), 32'd1);
        check("bne_n_pc_src",   32'(bus.pc_src), 32'd0);
        check("bne_n_reg_we",   32'(bus.reg_we), 32'd0);
        step();
        bus.alu_zero = 1'b0;
        check("bne_n_state",    32'(bus.state), 32'd0);
        check("bne_n_instret",  bus.instret, 32'd3);
        check("bne_n_latency",  cyc - t0, 32'd3);

        // lw x6,4(x1), stray imem_ack in DECODE, dmem_ack after 3 wait cycles
        fetch(LW_X6);
        bus.instr    = R_TYPE;
        bus.imem_ack = 1'b1;
        step();
        bus.imem_ack = 1'b0;
        check("lw_ex_state",    32'(bus.state), 32'd2);
        check("lw_ir_stable",   bus.ir, LW_X6);
        check("lw_ex_alusrc",   32'(bus.alu_src), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("lw_mem_state", 32'(bus.state), 32'd3);
            check("lw_mem_req",   32'(bus.dmem_req), 32'd1);
            check("lw_mem_alusrc", 32'(bus.alu_src), 32'd1);
        end
        step();
        bus.dmem_ack = 1'b1;
        #1;
        check("lw_mem4_state",  32'(bus.state), 32'd3);
        check("lw_mem4_req",    32'(bus.dmem_req), 32'd1);
        step();
        bus.dmem_ack = 1'b0;
        check("lw_wb_state",    32'(bus.state), 32'd4);
        check("lw_wb_reg_we",   32'(bus.reg_we), 32'd1);
        check("lw_wb_res",      32'(bus.result_src), 32'd1);
        check("lw_wb_pc_we",    32'(bus.pc_we), 32'd1);
        check("lw_wb_dmem_req", 32'(bus.dmem_req), 32'd0);
        step();
        check("lw_end_state",   32'(bus.state), 32'd0);
        check("lw_instret",     bus.instret, 32'd4);
        check("lw_latency",     cyc - t0, 32'd8);

        // addi x0,x0,1: write to x0 suppressed, still retires
        fetch(ADDI_X0);
        step();
        step();
        check("x0_wb_reg_we",   32'(bus.reg_we), 32'd0);
        check("x0_wb_pc_we",    32'(bus.pc_we), 32'd1);
        step();
        check("x0_instret",     bus.instret, 32'd5);

        // instret wrap: preload all-ones while idle in FETCH
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        check("wrap_preload",   bus.instret, 32'hFFFF_FFFF);
        run_addi(ADDI_X5);
        check("wrap_instret",   bus.instret, 32'd0);
        run_addi(ADDI_X5);
        check("post_wrap",      bus.instret, 32'd1);

        // Reset during MEM, colliding with dmem_ack: reset wins, no retire
        fetch(LW_X6);
        step();
        step();
        check("rstmem_state",   32'(bus.state), 32'd3);
        bus.dmem_ack = 1'b1;
        rst_n        = 1'b0;
        step();
        rst_n        = 1'b1;
        bus.dmem_ack = 1'b0;
        #1;
        check("rstmem_state0",  32'(bus.state), 32'd0);
        check("rstmem_dmem",    32'(bus.dmem_req), 32'd0);
        check("rstmem_instret", bus.instret, 32'd0);
        check("rstmem_ir",      bus.ir, 32'd0);
        check("rstmem_reg_we",  32'(bus.reg_we), 32'd0);

        // Illegal R-type: sticky trap, frozen instret, exit only by reset
        run_addi(ADDI_X5);
        fetch(R_TYPE);
        check("trap_dec_state", 32'(bus.state), 32'd1);
        step();
        for (int i = 0; i < 10; i++) begin
            bus.imem_ack = 1'b1;
            bus.dmem_ack = 1'b1;
            #1;
            check("trap_state",    32'(bus.state), 32'd5);
            check("trap_illegal",  32'(bus.illegal), 32'd1);
            check("trap_imem_req", 32'(bus.imem_req), 32'd0);
            check("trap_pc_we",    32'(bus.pc_we), 32'd0);
            check("trap_instret",  bus.instret, 32'd1);
            step();
        end
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        rst_n        = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check("trap_rst_state",   32'(bus.state), 32'd0);
        check("trap_rst_illegal", 32'(bus.illegal), 32'd0);
        check("trap_rst_imem",    32'(bus.imem_req), 32'd1);
        check("trap_rst_instret", bus.instret, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, 32, instruction and counter width.
REQ-002 Parameter OPCODE_WIDTH, 7, opcode field width (instr[6:0]).
REQ-003 Parameter ALU_WIDTH, 3, alu_ctrl width; IMM_WIDTH, 3, imm_src width.
REQ-004 One clock; reset is synchronous and active-low. Ports: clk  in  1  rising-edge clock; rst_n  in  1  synchronous active-low reset.
REQ-005 imem_req  out  1  instruction fetch request; imem_ack  in  1  fetch complete, instr valid.
REQ-006 instr  in  DATA_WIDTH  fetched instruction; ir  out  DATA_WIDTH  latched instruction register.
REQ-007 dmem_req  out  1  data load request; dmem_ack  in  1  load data valid.
REQ-008 alu_zero  in  1  ALU result == 0.
REQ-009 alu_ctrl  out  ALU_WIDTH  ALU op: SUM_OP=000, SUB_OP=001, AND_OP=010, SLT_OP=101.
REQ-010 alu_src  out  1  0 = rs2, 1 = immediate; imm_src  out  IMM_WIDTH  Imm=0, UpperImm=1, Store=2, Branch=3, Jump=4.
REQ-011 reg_we  out  1  regfile write strobe; result_src  out  1  0 = ALU, 1 = load data.
REQ-012 pc_we  out  1  PC update strobe; pc_src  out  1  0 = PC+4, 1 = PC+branch imm.
REQ-013 illegal  out  1  sticky trap flag; instret  out  DATA_WIDTH  retired count; state  out  3  current FSM state.

Function
REQ-014 States (encoding): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 go to FETCH next cycle, all strobes 0.
REQ-015 Defaults when a state does not drive them: all strobes 0, alu_ctrl=SUM_OP, alu_src=0, imm_src=Imm, pc_src=0, result_src=0.
REQ-016 FETCH: imem_req=1, held until imem_ack; on imem_ack, ir<=instr, ->DECODE; else remain.
REQ-017 imem_ack outside FETCH and dmem_ack outside MEM are ignored.
REQ-018 DECODE: legal = (opcode 0010011, funct3 000: addi) | (1100011, 001: bne) | (0000011, 010: lw); legal ->EXEC, else ->TRAP.
REQ-019 EXEC addi: alu_ctrl=SUM_OP, alu_src=1, imm_src=Imm, ->WB.
REQ-020 EXEC bne: alu_ctrl=SUB_OP, alu_src=0, imm_src=Branch, pc_we=1, pc_src=~alu_zero, instret+1, ->FETCH.
REQ-021 EXEC lw: alu_ctrl=SUM_OP, alu_src=1, imm_src=Imm, ->MEM.
REQ-022 MEM: dmem_req=1, SUM_OP/alu_src=1/Imm held; on dmem_ack ->WB, else remain.
REQ-023 WB: reg_we=1 unless ir[11:7]==0 (x0 writes suppressed); result_src=1 for lw, 0 for addi; ALU controls as EXEC; pc_we=1, pc_src=0; instret+1; ->FETCH.
REQ-024 Latency with same-cycle ack: bne 3 cycles, addi 4, lw 5; each wait cycle adds one.
REQ-025 TRAP: illegal=1, all strobes 0, instret frozen, exit only by reset.
REQ-026 instret wraps 2^32-1 -> 0; exactly one increment per retired instruction.
REQ-027 pc_we asserted exactly one cycle per retired instruction.
REQ-028 ir changes only at the FETCH accept edge.

Reset
REQ-029 rst_n low at a rising edge, from any state incl. mid-request: state=FETCH, ir=0, instret=0, illegal=0; outstanding requests dropped, no retire.
REQ-030 Reset-value outputs in first cycle after reset released: imem_req=1 (FETCH), all other strobes 0, defaults per REQ-015.
REQ-031 Reset has priority over any same-cycle ack or transition.

Verification
REQ-032 addi x5,x0,7 (0x00700293), imem_ack immediate -> states 0,1,2,4,0; reg_we=1 in WB only; instret 0->1; pc_we one cycle.
REQ-033 bne x1,x2,+8, alu_zero=0 -> EXEC pc_we=1, pc_src=1; alu_zero=1 -> pc_src=0; 3 cycles each, no reg_we.
REQ-034 lw x6,4(x1) (0x0040A303), dmem_ack delayed 3 cycles -> dmem_req held 4 cycles in MEM, WB reg_we=1, result_src=1; 8 cycles total.
REQ-035 addi x0,x0,1 (0x00100013) -> WB reg_we=0, pc_we=1, instret+1.
REQ-036 instr 0x00000033 (R-type) -> TRAP, illegal=1 sticky across 10 cycles, imem_req=0; rst_n low one edge -> FETCH, illegal=0.
REQ-037 instret preloaded path to 0xFFFFFFFF, one addi -> instret=0; rst_n low during MEM -> FETCH next cycle, dmem_req=0, instret=0.
